// File: rtl/cp0_exc_handler.sv
// CP0 exception endpoint at the M stage: merges exception codes with masked interrupts,
// keeps SR/Cause/EPC and serves mfc0/mtc0/eret. Define CP0_BADVADDR_EN to add BadVAddr (reg 8).
module cp0_exc_handler #(
   parameter logic [31:0] PRID      = 32'h4C4D_0700,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ExcCodeIn,
   input  logic [31:0] PCIn,
   input  logic        BDIn,
   input  logic [5:0]  HWInt,
   input  logic        WE,
   input  logic [4:0]  A,
   input  logic [31:0] DIn,
   input  logic        EretIn,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] AddrIn,
`endif
   output logic        IntReq,
   output logic [31:0] ExcEntry,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [29:0] epc_hi;
   logic        int_pend;
   logic        exc_pend;
   logic [4:0]  next_code;
   logic [29:0] epc_src;
   logic        unused_pcin;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr;
`endif

   assign int_pend  = (|(HWInt & im)) & ie & ~exl;
   assign exc_pend  = (ExcCodeIn != 5'd0) & ~exl;
   // Gated by reset so nothing redirects the pipeline while CP0 is held in reset.
   assign IntReq    = reset & (int_pend | exc_pend);
   assign next_code = int_pend ? 5'd0 : ExcCodeIn;
   // PC-4 only touches bits [31:2], so the word-aligned EPC is a 30-bit decrement.
   assign epc_src   = BDIn ? (PCIn[31:2] - 30'd1) : PCIn[31:2];
   assign unused_pcin = ^PCIn[1:0];

   assign ExcEntry = EXC_ENTRY;
   assign EPCOut   = {epc_hi, 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc_hi   <= 30'd0;
      end else begin
         ip <= HWInt;
         if (IntReq) begin
            exl      <= 1'b1;
            bd       <= BDIn;
            exc_code <= next_code;
            epc_hi   <= epc_src;
         end else begin
            if (EretIn)
               exl <= 1'b0;
            // mtc0 to SR comes after eret so it wins on EXL when both are present.
            if (WE) begin
               case (A)
                  5'd12: begin
                     im  <= DIn[15:10];
                     exl <= DIn[1];
                     ie  <= DIn[0];
                  end
                  5'd14: epc_hi <= DIn[31:2];
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         badvaddr <= 32'd0;
      else if (IntReq && (next_code == 5'd4 || next_code == 5'd5))
         badvaddr <= AddrIn;
   end
`endif

   always_comb begin
      DOut = 32'd0;
      case (A)
`ifdef CP0_BADVADDR_EN
         5'd8:  DOut = badvaddr;
`endif
         5'd12: DOut = {16'd0, im, 8'd0, exl, ie};
         5'd13: DOut = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
         5'd14: DOut = {epc_hi, 2'b00};
         5'd15: DOut = PRID;
         default: DOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Bench for cp0_exc_handler: directed vector table, hand sequences and a randomized run
// checked against a register-image model of CP0.
module tb_cp0_exc_handler;

   localparam logic [31:0] PRID      = 32'h4C4D_0700;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

   logic        clk;
   logic        reset;
   logic [4:0]  ExcCodeIn;
   logic [31:0] PCIn;
   logic        BDIn;
   logic [5:0]  HWInt;
   logic        WE;
   logic [4:0]  A;
   logic [31:0] DIn;
   logic        EretIn;
   logic [31:0] AddrIn;
   logic        IntReq;
   logic [31:0] ExcEntry;
   logic [31:0] EPCOut;
   logic [31:0] DOut;

   int checks   = 0;
   int failures = 0;

   cp0_exc_handler #(.PRID(PRID), .EXC_ENTRY(EXC_ENTRY)) dut (
      .clk(clk), .reset(reset), .ExcCodeIn(ExcCodeIn), .PCIn(PCIn), .BDIn(BDIn),
      .HWInt(HWInt), .WE(WE), .A(A), .DIn(DIn), .EretIn(EretIn),
`ifdef CP0_BADVADDR_EN
      .AddrIn(AddrIn),
`endif
      .IntReq(IntReq), .ExcEntry(ExcEntry), .EPCOut(EPCOut), .DOut(DOut)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: CP0 registers as plain 32-bit register images
   logic [31:0] m_sr, m_cause, m_epc, m_bva;

   task automatic m_reset();
      m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
   endtask

   function automatic logic m_int();
      logic [31:0] lines;
      lines = 32'(HWInt) << 10;
      return ((lines & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic logic m_req();
      return m_int() || ((ExcCodeIn != 0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
`ifdef CP0_BADVADDR_EN
         8:  return m_bva;
`endif
         12: return m_sr;
         13: return m_cause;
         14: return m_epc;
         15: return PRID;
         default: return 0;
      endcase
   endfunction

   task automatic m_edge();
      logic [31:0] ip_img;
      logic [31:0] code;
      ip_img = 32'(HWInt) << 10;
      if (m_req()) begin
         code    = m_int() ? 0 : 32'(ExcCodeIn);
         m_sr    = m_sr | 32'h2;
         m_cause = (32'(BDIn) << 31) | ip_img | (code << 2);
         m_epc   = (BDIn ? PCIn - 32'd4 : PCIn) & ~32'h3;
         if (code == 4 || code == 5) m_bva = AddrIn;
      end else begin
         m_cause = (m_cause & ~32'h0000_FC00) | ip_img;
         if (EretIn) m_sr = m_sr & ~32'h2;
         if (WE && A == 12) m_sr = DIn & 32'h0000_FC03;
         if (WE && A == 14) m_epc = DIn & ~32'h3;
      end
   endtask

   // driver tasks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] din,
                        input logic [4:0] exc, input logic [31:0] pc, input logic bd,
                        input logic [5:0] hw, input logic eret, input logic [31:0] addr);
      WE = we; A = a; DIn = din; ExcCodeIn = exc; PCIn = pc; BDIn = bd;
      HWInt = hw; EretIn = eret; AddrIn = addr;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // clock edge with the model updated from the same pre-edge inputs
   task automatic step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   // directed vector table
   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] din;
      logic [4:0]  exc;
      logic [31:0] pc;
      logic        bd;
      logic [5:0]  hw;
      logic        eret;
      logic        exp_req;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic we, logic [4:0] a, logic [31:0] din, logic [4:0] exc,
                               logic [31:0] pc, logic bd, logic [5:0] hw, logic eret,
                               logic exp_req, logic [31:0] exp_dout);
      vec_t v;
      v.we = we; v.a = a; v.din = din; v.exc = exc; v.pc = pc; v.bd = bd;
      v.hw = hw; v.eret = eret; v.exp_req = exp_req; v.exp_dout = exp_dout;
      return v;
   endfunction

   logic [4:0] codes[4];
   logic [4:0] regs[5];

   initial begin
      codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
      regs[0] = 5'd8; regs[1] = 5'd12; regs[2] = 5'd13; regs[3] = 5'd14; regs[4] = 5'd15;

      //          we a   din           exc pc            bd hw     eret req dout
      vecs.push_back(mk(0, 13, 0,            12, 32'h3010,     1, 6'h00, 0, 1, 32'h0));
      vecs.push_back(mk(0, 13, 0,            0,  0,            0, 6'h00, 0, 0, 32'h8000_0030));
      vecs.push_back(mk(0, 14, 0,            0,  0,            0, 6'h00, 0, 0, 32'h0000_300C));
      vecs.push_back(mk(0, 12, 0,            0,  0,            0, 6'h00, 0, 0, 32'h0000_0002));
      vecs.push_back(mk(0, 12, 0,            4,  32'h3100,     0, 6'h00, 0, 0, 32'h0000_0002));
      vecs.push_back(mk(0, 14, 0,            0,  0,            0, 6'h00, 1, 0, 32'h0000_300C));
      vecs.push_back(mk(1, 12, 32'h401,      0,  0,            0, 6'h00, 0, 0, 32'h0));
      vecs.push_back(mk(0, 12, 0,            0,  32'h4000,     0, 6'h01, 0, 1, 32'h0000_0401));
      vecs.push_back(mk(0, 13, 0,            0,  0,            0, 6'h01, 0, 0, 32'h0000_0400));
      vecs.push_back(mk(0, 14, 0,            0,  0,            0, 6'h00, 0, 0, 32'h0000_4000));
      vecs.push_back(mk(1, 12, 32'h001,      0,  0,            0, 6'h20, 0, 0, 32'h0000_0403));
      vecs.push_back(mk(0, 13, 0,            0,  0,            0, 6'h20, 0, 0, 32'h0000_8000));
      vecs.push_back(mk(1, 12, 32'hFC01,     0,  0,            0, 6'h20, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(1, 14, 32'hFFFF,     10, 32'h5004,     0, 6'h20, 0, 1, 32'h0000_4000));
      vecs.push_back(mk(0, 14, 0,            0,  0,            0, 6'h20, 0, 0, 32'h0000_5004));
      vecs.push_back(mk(0, 13, 0,            0,  0,            0, 6'h20, 0, 0, 32'h0000_8000));
      vecs.push_back(mk(0, 15, 0,            0,  0,            0, 6'h20, 0, 0, PRID));
      vecs.push_back(mk(0, 8,  0,            0,  0,            0, 6'h20, 0, 0, 32'h0));
      vecs.push_back(mk(1, 12, 32'h3,        0,  0,            0, 6'h00, 1, 0, 32'h0000_FC03));
      vecs.push_back(mk(0, 12, 0,            0,  0,            0, 6'h00, 0, 0, 32'h0000_0003));
      vecs.push_back(mk(0, 12, 0,            0,  0,            0, 6'h00, 1, 0, 32'h0000_0003));
      vecs.push_back(mk(0, 12, 0,            0,  0,            0, 6'h00, 0, 0, 32'h0000_0001));
      vecs.push_back(mk(0, 14, 0,            12, 32'h0000_0002, 1, 6'h00, 0, 1, 32'h0000_5004));
      vecs.push_back(mk(0, 14, 0,            0,  0,            0, 6'h00, 0, 0, 32'hFFFF_FFFC));
      vecs.push_back(mk(1, 13, 32'hFFFF_FFFF, 0, 0,            0, 6'h00, 0, 0, 32'h8000_0030));
      vecs.push_back(mk(0, 13, 0,            0,  0,            0, 6'h00, 0, 0, 32'h8000_0030));
      vecs.push_back(mk(1, 9,  32'h1234_5678, 0, 0,            0, 6'h00, 0, 0, 32'h0));
      vecs.push_back(mk(0, 9,  0,            0,  0,            0, 6'h00, 0, 0, 32'h0));

      // power-on reset: everything zero, no request even with an exception code present
      reset = 1'b0;
      m_reset();
      drive(0, 12, 0, 12, 32'h100, 0, 6'h3F, 0, 0);
      repeat (2) @(negedge clk);
      check("reset_intreq", 32'(IntReq), 32'd0);
      check("reset_sr", DOut, 32'd0);
      A = 13; #1;
      check("reset_cause", DOut, 32'd0);
      check("reset_epcout", EPCOut, 32'd0);
      check("exc_entry", ExcEntry, EXC_ENTRY);
      idle();
      reset = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].a, vecs[i].din, vecs[i].exc, vecs[i].pc, vecs[i].bd,
               vecs[i].hw, vecs[i].eret, 0);
         check($sformatf("vec%0d_intreq", i), 32'(IntReq), 32'(vecs[i].exp_req));
         check($sformatf("vec%0d_dout", i), DOut, vecs[i].exp_dout);
         step();
      end

`ifdef CP0_BADVADDR_EN
      // address error store records the faulting data address
      drive(1, 12, 32'h0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 8, 0, 5, 32'h6000, 0, 0, 0, 32'h0000_2003);
      check("bva_intreq", 32'(IntReq), 32'd1);
      step();
      idle(); A = 8; #1;
      check("bva_read", DOut, 32'h0000_2003);
`endif

      // randomized run against the model
      for (int n = 0; n < 600; n++) begin
         int r;
         logic [4:0] exc;
         logic [4:0] a;
         r = $urandom_range(0, 9);
         exc = (r < 6) ? 5'd0 : codes[r - 6];
         r = $urandom_range(0, 6);
         a = (r < 5) ? regs[r] : 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 3) == 0), a,
               (($urandom_range(0, 1) == 0) ? ($urandom() & 32'h0000_FC01) : $urandom()),
               exc, $urandom(), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
               ($urandom_range(0, 3) == 0), $urandom());
         check("rand_intreq", 32'(IntReq), 32'(m_req()));
         check("rand_dout", DOut, m_read(A));
         check("rand_epcout", EPCOut, m_epc);
         step();
      end

      // asynchronous reset mid-operation with EXL=1 and EPC=0x3008
      drive(1, 12, 32'h0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 14, 0, 4, 32'h3008, 0, 0, 0, 0);
      check("pre_reset_intreq", 32'(IntReq), 32'd1);
      step();
      idle(); A = 14; #1;
      check("pre_reset_epc", DOut, 32'h0000_3008);
      A = 12; #1;
      check("pre_reset_exl", DOut, 32'h0000_0002);
      ExcCodeIn = 5'd12; #2;
      reset = 1'b0;
      m_reset();
      #1;
      check("async_reset_sr", DOut, 32'd0);
      check("async_reset_intreq", 32'(IntReq), 32'd0);
      check("async_reset_epcout", EPCOut, 32'd0);
      A = 13; #1;
      check("async_reset_cause", DOut, 32'd0);
      A = 14; #1;
      check("async_reset_epc", DOut, 32'd0);
      @(negedge clk);
      idle(); A = 12;
      reset = 1'b1;
      step();
      check("post_reset_sr", DOut, 32'd0);
      check("post_reset_intreq", 32'(IntReq), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
